// File: rtl/load_register.sv
// load_register: width-parameterised load-enable register with per-byte
// write enables, synchronous clear, previous-value shadow and update pulse.
module load_register #(
   parameter int unsigned      WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     in,
   input  logic                 load,
   input  logic [WIDTH/8-1:0]   byte_en,
   input  logic                 clear,
   output logic [WIDTH-1:0]     out,
   output logic [WIDTH-1:0]     prev_out,
   output logic                 updated
);

   localparam int unsigned NBYTES = WIDTH / 8;

   logic [WIDTH-1:0] out_q,  out_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic             upd_q,  upd_d;
   logic [WIDTH-1:0] merged;

   // Byte-masked merge of the incoming word over the stored word; masked
   // lanes come only from out_q so X on those input bytes cannot leak in.
   always_comb begin
      merged = out_q;
      for (int unsigned k = 0; k < NBYTES; k++) begin
         if (byte_en[k]) begin
            merged[k*8 +: 8] = in[k*8 +: 8];
         end
      end
   end

   // Next-state: clear beats load; shadow and pulse only on a real change.
   always_comb begin
      out_d  = out_q;
      prev_d = prev_q;
      upd_d  = 1'b0;
      if (clear) begin
         if (out_q != RESET_VALUE) begin
            out_d  = RESET_VALUE;
            prev_d = out_q;
            upd_d  = 1'b1;
         end
      end else if (load) begin
         if (merged != out_q) begin
            out_d  = merged;
            prev_d = out_q;
            upd_d  = 1'b1;
         end
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q  <= RESET_VALUE;
         prev_q <= RESET_VALUE;
         upd_q  <= 1'b0;
      end else begin
         out_q  <= out_d;
         prev_q <= prev_d;
         upd_q  <= upd_d;
      end
   end

   assign out      = out_q;
   assign prev_out = prev_q;
   assign updated  = upd_q;

endmodule

// File: tb/tb_load_register.sv
// tb_load_register: vector table plus random soak; expectations queued at
// the driving edge and compared one step later.
module tb_load_register;

   localparam int unsigned W = 16;

   logic          clk;
   logic          reset;
   logic [W-1:0]  in;
   logic          load;
   logic [1:0]    byte_en;
   logic          clear;
   logic [W-1:0]  out;
   logic [W-1:0]  prev_out;
   logic          updated;

   typedef struct {
      logic          rst;
      logic          clr;
      logic          ld;
      logic [1:0]    be;
      logic [W-1:0]  din;
      logic [W-1:0]  e_out;
      logic [W-1:0]  e_prev;
      logic          e_upd;
   } vec_t;

   typedef struct {
      logic [W-1:0]  e_out;
      logic [W-1:0]  e_prev;
      logic          e_upd;
      string         name;
   } exp_t;

   exp_t  sb[$];
   vec_t  vecs[19];
   int    total = 0;
   int    bad   = 0;

   logic [W-1:0] m_out, m_prev;
   logic         m_upd;

   load_register #(.WIDTH(W), .RESET_VALUE(16'h0000)) dut (
      .clk      (clk),
      .reset    (reset),
      .in       (in),
      .load     (load),
      .byte_en  (byte_en),
      .clear    (clear),
      .out      (out),
      .prev_out (prev_out),
      .updated  (updated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic c, logic l, logic [1:0] b,
                               logic [W-1:0] d, logic [W-1:0] eo,
                               logic [W-1:0] ep, logic eu);
      vec_t v;
      v.rst = r; v.clr = c; v.ld = l; v.be = b; v.din = d;
      v.e_out = eo; v.e_prev = ep; v.e_upd = eu;
      return v;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drive one edge, queue its expectation, then compare after the edge.
   task automatic step(input logic r, input logic c, input logic l,
                       input logic [1:0] b, input logic [W-1:0] d,
                       input exp_t e);
      exp_t got;
      reset = r; clear = c; load = l; byte_en = b; in = d;
      @(posedge clk);
      sb.push_back(e);
      #1;
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard_empty: got 0 entries want 1");
      end else begin
         got = sb.pop_front();
         check({got.name, ".out"},      out,                 got.e_out);
         check({got.name, ".prev_out"}, prev_out,            got.e_prev);
         check({got.name, ".updated"},  {15'd0, updated},    {15'd0, got.e_upd});
      end
   endtask

   initial begin
      exp_t e;
      logic [W-1:0] rin;
      logic         rld;

      vecs[0]  = mk(1, 0, 1, 2'b11, 16'hBEEF, 16'h0000, 16'h0000, 0);
      vecs[1]  = mk(1, 0, 1, 2'b11, 16'hBEEF, 16'h0000, 16'h0000, 0);
      vecs[2]  = mk(0, 0, 1, 2'b11, 16'h3524, 16'h3524, 16'h0000, 1);
      vecs[3]  = mk(0, 0, 0, 2'b11, 16'h5E81, 16'h3524, 16'h0000, 0);
      vecs[4]  = mk(0, 0, 0, 2'b11, 16'h5E81, 16'h3524, 16'h0000, 0);
      vecs[5]  = mk(0, 0, 0, 2'b11, 16'h5E81, 16'h3524, 16'h0000, 0);
      vecs[6]  = mk(0, 0, 1, 2'b01, 16'hD609, 16'h3509, 16'h3524, 1);
      vecs[7]  = mk(0, 0, 1, 2'b00, 16'hFFFF, 16'h3509, 16'h3524, 0);
      vecs[8]  = mk(0, 0, 1, 2'b11, 16'h1234, 16'h1234, 16'h3509, 1);
      vecs[9]  = mk(0, 0, 1, 2'b11, 16'h1234, 16'h1234, 16'h3509, 0);
      vecs[10] = mk(0, 0, 1, 2'b11, 16'h00AA, 16'h00AA, 16'h1234, 1);
      vecs[11] = mk(0, 1, 1, 2'b11, 16'h7777, 16'h0000, 16'h00AA, 1);
      vecs[12] = mk(0, 1, 0, 2'b11, 16'h7777, 16'h0000, 16'h00AA, 0);
      vecs[13] = mk(0, 0, 1, 2'b11, 16'h00AA, 16'h00AA, 16'h0000, 1);
      vecs[14] = mk(1, 0, 1, 2'b11, 16'h7777, 16'h0000, 16'h0000, 0);
      vecs[15] = mk(0, 0, 1, 2'b11, 16'h7777, 16'h7777, 16'h0000, 1);
      vecs[16] = mk(0, 0, 1, 2'b11, 16'h7778, 16'h7778, 16'h7777, 1);
      vecs[17] = mk(0, 0, 0, 2'b11, 16'h0000, 16'h7778, 16'h7777, 0);
      vecs[18] = mk(0, 0, 1, 2'b01, 16'hxx55, 16'h7755, 16'h7778, 1);

      reset = 1'b1; clear = 1'b0; load = 1'b0; byte_en = 2'b11; in = '0;

      for (int i = 0; i < 19; i++) begin
         e.e_out  = vecs[i].e_out;
         e.e_prev = vecs[i].e_prev;
         e.e_upd  = vecs[i].e_upd;
         e.name   = $sformatf("vec%0d", i);
         step(vecs[i].rst, vecs[i].clr, vecs[i].ld, vecs[i].be, vecs[i].din, e);
      end

      // Pending load followed by reset: reset wins, load is lost.
      e.e_out = 16'h4321; e.e_prev = 16'h7755; e.e_upd = 1'b1; e.name = "seq_ld";
      step(0, 0, 1, 2'b11, 16'h4321, e);
      e.e_out = 16'h0000; e.e_prev = 16'h0000; e.e_upd = 1'b0; e.name = "seq_rst";
      step(1, 1, 1, 2'b11, 16'h9999, e);
      e.e_out = 16'h0000; e.e_prev = 16'h0000; e.e_upd = 1'b0; e.name = "seq_idle";
      step(0, 0, 0, 2'b11, 16'h9999, e);

      // Random soak against a behavioural model.
      m_out = 16'h0000; m_prev = 16'h0000;
      for (int it = 0; it < 10; it++) begin
         rin = W'($urandom);
         rld = 1'($urandom_range(0, 1));
         for (int c = 0; c < 4; c++) begin
            m_upd = 1'b0;
            if (rld && rin != m_out) begin
               m_prev = m_out;
               m_out  = rin;
               m_upd  = 1'b1;
            end
            e.e_out = m_out; e.e_prev = m_prev; e.e_upd = m_upd;
            e.name  = $sformatf("soak%0d_%0d", it, c);
            step(0, 0, rld, 2'b11, rin, e);
         end
      end

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
